ntt_stage_sequencer: RTL and testbench

NTT_STAGE_SEQUENCER -- requirements
Module: ntt_stage_sequencer

---
 rtl/ntt_stage_sequencer.sv | 155 +++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 NTT: walks LOGN stages of N/2
// butterflies, pipelines read addresses to the write port, and pauses between stages.
module ntt_stage_sequencer #(
  parameter int W    = 32,
  parameter int N    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode_in,
  output logic            busy,
  output logic            done,
  output logic            iNTT_mode,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  input  logic [W-1:0]    rd_data_a,
  input  logic [W-1:0]    rd_data_b,
  output logic [W-1:0]    bf_A_in,
  output logic [W-1:0]    bf_B_in,
  input  logic [W-1:0]    bf_A_out,
  input  logic [W-1:0]    bf_B_out,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [W-1:0]    wr_data_a,
  output logic [W-1:0]    wr_data_b
);

  localparam int SW = $clog2(LOGN + 1);
  localparam int JW = LOGN - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [JW-1:0]   j_q, j_d;
  logic            drain_q, drain_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic            vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [LOGN-1:0] addr_a_p1_q, addr_a_p1_d, addr_b_p1_q, addr_b_p1_d;
  logic [LOGN-1:0] addr_a_p2_q, addr_a_p2_d, addr_b_p2_q, addr_b_p2_d;

  logic [LOGN-1:0] j_ext, m_w, k_w, g_w, addr_a_w;

  // Butterfly j of stage s pairs a and a+m inside group g; twiddle index k scaled to N/2 entries.
  always_comb begin
    j_ext     = {1'b0, j_q};
    m_w       = LOGN'(1) << s_q;
    k_w       = j_ext & (m_w - LOGN'(1));
    g_w       = j_ext >> s_q;
    addr_a_w  = (g_w << (s_q + SW'(1))) | k_w;
    rd_addr_a = addr_a_w;
    rd_addr_b = addr_a_w + m_w;
    tw_addr   = JW'(k_w) << (SW'(LOGN - 1) - s_q);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
          mode_d  = mode_in;
        end
      end
      RUN: begin
        if (j_q == JW'(N / 2 - 1)) begin
          j_d     = '0;
          s_d     = s_q + SW'(1);
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = (s_q == SW'(LOGN)) ? DONE : RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    rd_en_d     = (state_d == RUN);
    vld_p1_d    = rd_en_q;
    vld_p2_d    = vld_p1_q;
    addr_a_p1_d = addr_a_w;
    addr_b_p1_d = addr_a_w + m_w;
    addr_a_p2_d = addr_a_p1_q;
    addr_b_p2_d = addr_b_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      j_q      <= '0;
      drain_q  <= 1'b0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      j_q      <= j_d;
      drain_q  <= drain_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // p1: read data returns / operands to butterfly; p2: butterfly result written back
  always_ff @(posedge clk) begin
    addr_a_p1_q <= addr_a_p1_d;
    addr_b_p1_q <= addr_b_p1_d;
    addr_a_p2_q <= addr_a_p2_d;
    addr_b_p2_q <= addr_b_p2_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign iNTT_mode = mode_q;
  assign rd_en     = rd_en_q;
  assign bf_A_in   = rd_data_a;
  assign bf_B_in   = rd_data_b;
  assign wr_en     = vld_p2_q;
  assign wr_addr_a = addr_a_p2_q;
  assign wr_addr_b = addr_b_p2_q;
  assign wr_data_a = bf_A_out;
  assign wr_data_b = bf_B_out;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: cycle-level schedule model, RAM/ROM/butterfly models,
// and an end-to-end forward/inverse NTT over Q=40961.
module tb_ntt_stage_sequencer;
  localparam int W = 32, N = 8, LOGN = 3;
  localparam longint Q = 40961;
  localparam int PER = N / 2 + 2;
  localparam int LAT = LOGN * PER + 1;

  logic clk, rst, start, mode_in;
  logic busy, done, iNTT_mode, rd_en, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] tw_addr;
  logic [W-1:0] rd_data_a, rd_data_b, bf_A_in, bf_B_in, bf_A_out, bf_B_out, wr_data_a, wr_data_b;

  ntt_stage_sequencer #(.W(W), .N(N), .LOGN(LOGN)) dut (
    .clk(clk), .reset(rst), .start(start), .mode_in(mode_in),
    .busy(busy), .done(done), .iNTT_mode(iNTT_mode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .bf_A_in(bf_A_in), .bf_B_in(bf_B_in), .bf_A_out(bf_A_out), .bf_B_out(bf_B_out),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] mem [N];
  logic [W-1:0] rom_f [N/2];
  logic [W-1:0] rom_i [N/2];
  logic [W-1:0] tw_q;
  logic ld_en, bf_real, chk_en;
  logic [LOGN-1:0] ld_addr;
  logic [W-1:0] ld_data;

  int cyc = 0, run_start = -1, sc = 0;
  logic mode_exp = 1'b0;
  int n_pass = 0, n_tot = 0;
  int wr_cnt, done_cnt, last_done;

  typedef struct { int a; int b; int tw; } trip_t;
  trip_t seq_q[$];
  int exp_seq [12][3] = '{
    '{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
    '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
    '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};

  function automatic longint mulmod(input longint a, input longint b);
    return (a * b) % Q;
  endfunction

  function automatic longint powmod(input longint b, input longint e);
    longint r = 1, x = b % Q, k = e;
    while (k > 0) begin
      if (k[0]) r = mulmod(r, x);
      x = mulmod(x, x);
      k = k >> 1;
    end
    return r;
  endfunction

  function automatic int bitrev(input int x);
    int r = 0;
    for (int i = 0; i < LOGN; i++) r |= ((x >> i) & 1) << (LOGN - 1 - i);
    return r;
  endfunction

  // Issue slot u (cycles after the start cycle) -> which butterfly, if any, is read.
  function automatic void issue(input int u, output bit v, output int a, output int b, output int tw);
    int s, j, m;
    v = 0; a = 0; b = 0; tw = 0;
    if (u >= 1 && u <= LOGN * PER) begin
      s = (u - 1) / PER;
      j = (u - 1) % PER;
      if (j < N / 2) begin
        v = 1;
        m = 1 << s;
        a = 2 * m * (j / m) + j % m;
        b = a + m;
        tw = (j % m) * (N / (2 * m));
      end
    end
  endfunction

  function automatic bit model_busy(input int c);
    int t;
    t = (run_start < 0) ? -1 : c - run_start;
    return (t >= 1 && t <= LAT);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    else n_pass++;
  endtask

  // Environment: coefficient RAM (1-cycle read), twiddle ROM, loader
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
    tw_q <= iNTT_mode ? rom_i[tw_addr] : rom_f[tw_addr];
  end

  // Butterfly: either identity register or modular Cooley-Tukey
  always @(posedge clk) begin
    if (bf_real) begin
      bf_A_out <= W'((longint'(bf_A_in) + mulmod(longint'(bf_B_in), longint'(tw_q))) % Q);
      bf_B_out <= W'((longint'(bf_A_in) + Q - mulmod(longint'(bf_B_in), longint'(tw_q))) % Q);
    end else begin
      bf_A_out <= bf_A_in;
      bf_B_out <= bf_B_in;
    end
  end

  // Model: tracks the accepted start cycle and latched mode
  always @(posedge clk) begin
    if (rst) begin
      run_start <= -1;
      mode_exp  <= 1'b0;
    end else if (start && !model_busy(cyc)) begin
      run_start <= cyc;
      mode_exp  <= mode_in;
    end
    cyc <= cyc + 1;
  end

  task automatic compare_cycle();
    int t, a, b, tw, wa, wb, dm;
    bit rv, wv;
    t = (run_start < 0) ? -1 : cyc - run_start;
    issue(t, rv, a, b, tw);
    issue(t - 2, wv, wa, wb, dm);
    chk("busy", busy, (t >= 1 && t <= LAT));
    chk("done", done, (t == LAT));
    chk("rd_en", rd_en, rv);
    chk("wr_en", wr_en, wv);
    chk("iNTT_mode", iNTT_mode, mode_exp);
    if (rv && rd_en === 1'b1) begin
      chk("rd_addr_a", rd_addr_a, a);
      chk("rd_addr_b", rd_addr_b, b);
      chk("tw_addr", tw_addr, tw);
      chk("bf_A_in", bf_A_in, rd_data_a);
      chk("bf_B_in", bf_B_in, rd_data_b);
    end
    if (wv && wr_en === 1'b1) begin
      chk("wr_addr_a", wr_addr_a, wa);
      chk("wr_addr_b", wr_addr_b, wb);
      chk("wr_data_a", wr_data_a, bf_A_out);
      chk("wr_data_b", wr_data_b, bf_B_out);
      if (!bf_real) begin
        chk("wr_align_a", wr_data_a, wr_addr_a);
        chk("wr_align_b", wr_data_b, wr_addr_b);
      end
    end
    if (rd_en === 1'b1) seq_q.push_back('{int'(rd_addr_a), int'(rd_addr_b), int'(tw_addr)});
    if (wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
  endtask

  always @(negedge clk) if (chk_en) compare_cycle();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input longint v);
    ld_en = 1'b1; ld_addr = LOGN'(i); ld_data = W'(v);
    tick();
    ld_en = 1'b0;
  endtask

  task automatic prep();
    seq_q.delete();
    wr_cnt = 0; done_cnt = 0; last_done = -1;
  endtask

  task automatic do_start(input bit m);
    start = 1'b1; mode_in = m; sc = cyc;
    tick();
    start = 1'b0; mode_in = 1'b0;
  endtask

  task automatic check_seq();
    chk("seq_len", seq_q.size(), 12);
    for (int i = 0; i < 12 && i < seq_q.size(); i++) begin
      chk("seq_a", seq_q[i].a, exp_seq[i][0]);
      chk("seq_b", seq_q[i].b, exp_seq[i][1]);
      chk("seq_tw", seq_q[i].tw, exp_seq[i][2]);
    end
  endtask

  task automatic check_full_run();
    check_seq();
    chk("write_count", wr_cnt, 12);
    chk("done_count", done_cnt, 1);
    chk("latency", last_done - sc, 19);
  endtask

  longint w, winv, ninv;
  longint x [N] = '{1, 2, 3, 4, 0, 0, 0, 0};
  longint xf [N];
  longint res [N];

  initial begin
    rst = 1'b1; start = 1'b0; mode_in = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; bf_real = 1'b0; chk_en = 1'b0;
    w = 0;
    for (longint g = 2; g < Q && w == 0; g++) begin
      longint c;
      c = powmod(g, (Q - 1) / N);
      if (powmod(c, N / 2) == Q - 1) w = c;
    end
    winv = powmod(w, N - 1);
    ninv = powmod(N, Q - 2);
    for (int i = 0; i < N / 2; i++) begin
      rom_f[i] = W'(powmod(w, i));
      rom_i[i] = W'(powmod(winv, i));
    end
    for (int k = 0; k < N; k++) begin
      xf[k] = 0;
      for (int n = 0; n < N; n++) xf[k] = (xf[k] + mulmod(x[n], powmod(w, n * k))) % Q;
    end

    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_mode", iNTT_mode, 0);

    for (int i = 0; i < N; i++) load(i, i);
    tick();

    // forward run, address-as-data RAM, identity butterfly
    prep(); do_start(1'b0);
    repeat (22) tick();
    check_full_run();

    // start pulses while busy must be ignored
    prep(); do_start(1'b0);
    repeat (4) tick();
    start = 1'b1; mode_in = 1'b1; tick(); start = 1'b0; mode_in = 1'b0;
    repeat (4) tick();
    start = 1'b1; mode_in = 1'b1; tick(); start = 1'b0; mode_in = 1'b0;
    repeat (12) tick();
    check_full_run();
    chk("busy_start_mode", iNTT_mode, 0);

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; mode_in = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; mode_in = 1'b0;
    repeat (3) tick();
    chk("rst_start_busy", busy, 0);
    chk("rst_start_mode", iNTT_mode, 0);

    // reset mid-run at cycle 8, then a fresh full run
    prep(); do_start(1'b0);
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (14) tick();
    chk("midrst_writes", wr_cnt, 4);
    chk("midrst_done", done_cnt, 0);
    chk("midrst_busy", busy, 0);
    prep(); do_start(1'b0);
    repeat (22) tick();
    check_full_run();

    // end-to-end forward then inverse NTT
    bf_real = 1'b1;
    for (int i = 0; i < N; i++) load(i, x[bitrev(i)]);
    tick();
    prep(); do_start(1'b0);
    repeat (22) tick();
    for (int k = 0; k < N; k++) begin
      res[k] = longint'(mem[k]);
      chk("ntt_fwd", res[k], xf[k]);
    end
    for (int i = 0; i < N; i++) load(i, res[bitrev(i)]);
    tick();
    prep(); do_start(1'b1);
    repeat (22) tick();
    chk("inv_done_count", done_cnt, 1);
    for (int n = 0; n < N; n++) chk("ntt_roundtrip", mulmod(longint'(mem[n]), ninv), x[n]);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
